// File: rtl/seq_pkg.sv
// Shared types and constants for the branch sequencer and its condition evaluator.
package seq_pkg;

   // Microstep counter width; must hold 0..MAX_STEP.
   localparam int unsigned STEP_W = 3;

   // Bit positions inside the flag word {V,C,Z,N}.
   localparam int unsigned FLAG_N = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   typedef enum logic [1:0] {
      FETCH_A = 2'd0,
      FETCH_B = 2'd1,
      EVAL    = 2'd2,
      EXEC    = 2'd3
   } state_t;

   typedef enum logic [3:0] {
      CC_EQ = 4'h0,
      CC_NE = 4'h1,
      CC_CS = 4'h2,
      CC_CC = 4'h3,
      CC_MI = 4'h4,
      CC_PL = 4'h5,
      CC_VS = 4'h6,
      CC_VC = 4'h7,
      CC_HI = 4'h8,
      CC_LS = 4'h9,
      CC_GE = 4'hA,
      CC_LT = 4'hB,
      CC_GT = 4'hC,
      CC_LE = 4'hD,
      CC_AL = 4'hE,
      CC_NV = 4'hF
   } cc_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: maps a 4-bit condition field and the
// {V,C,Z,N} flag word to a single taken/not-taken result.
module cond_eval
   import seq_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] fin,
   output logic       result
);

   logic n, z, c, v;

   assign n = fin[FLAG_N];
   assign z = fin[FLAG_Z];
   assign c = fin[FLAG_C];
   assign v = fin[FLAG_V];

   // Decode the condition field against the individual flags.
   always_comb begin
      result = 1'b0;
      case (cc_t'(cond))
         CC_EQ: result = z;
         CC_NE: result = !z;
         CC_CS: result = c;
         CC_CC: result = !c;
         CC_MI: result = n;
         CC_PL: result = !n;
         CC_VS: result = v;
         CC_VC: result = !v;
         CC_HI: result = c && !z;
         CC_LS: result = !c || z;
         CC_GE: result = (n == v);
         CC_LT: result = (n != v);
         CC_GT: result = !z && (n == v);
         CC_LE: result = z || (n != v);
         CC_AL: result = 1'b1;
         CC_NV: result = 1'b0;
         default: result = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch/decode microstep sequencer: latches the instruction byte, evaluates
// branch conditions against the flags in a dedicated step, and returns to
// fetch on untaken branches, end-of-instruction or microstep overrun.
module branch_sequencer
   import seq_pkg::*;
#(
   parameter logic [3:0]  BRANCH_OP = 4'hE,
   parameter int unsigned MAX_STEP  = 7
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        bus,
   input  logic [3:0]        fin,
   input  logic              stall,
   input  logic              step_last,
   output logic [STEP_W-1:0] step,
   output logic [7:0]        ir,
   output logic              ir_load,
   output logic              taken,
   output logic              abort,
   output logic              overrun
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEP);
   localparam logic [STEP_W-1:0] STEP_EXEC = STEP_W'(3);

   state_t state;
   logic   cond_res;
   logic   is_branch;

   cond_eval u_cond_eval (
      .cond   (ir[3:0]),
      .fin    (fin),
      .result (cond_res)
   );

   assign is_branch = (ir[7:4] == BRANCH_OP);
   assign ir_load   = (step == STEP_W'(1)) && !stall;

   // Sequencer state, microstep counter, instruction latch and registered pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH_A;
         step    <= '0;
         ir      <= '0;
         taken   <= 1'b0;
         abort   <= 1'b0;
         overrun <= 1'b0;
      end else if (stall) begin
         abort   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         abort   <= 1'b0;
         overrun <= 1'b0;
         case (state)
            FETCH_A: begin
               state <= FETCH_B;
               step  <= STEP_W'(1);
            end
            FETCH_B: begin
               state <= EVAL;
               step  <= STEP_W'(2);
               ir    <= bus;
            end
            EVAL: begin
               if (is_branch) begin
                  taken <= cond_res;
                  if (cond_res) begin
                     state <= EXEC;
                     step  <= STEP_EXEC;
                  end else begin
                     abort <= 1'b1;
                     state <= FETCH_A;
                     step  <= '0;
                  end
               end else begin
                  taken <= 1'b1;
                  if (step_last) begin
                     state <= FETCH_A;
                     step  <= '0;
                  end else begin
                     state <= EXEC;
                     step  <= STEP_EXEC;
                  end
               end
            end
            EXEC: begin
               if (step_last) begin
                  state <= FETCH_A;
                  step  <= '0;
               end else if (step == LAST_STEP) begin
                  overrun <= 1'b1;
                  state   <= FETCH_A;
                  step    <= '0;
               end else begin
                  step <= step + STEP_W'(1);
               end
            end
            default: begin
               state <= FETCH_A;
               step  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer plus exhaustive check of cond_eval.
module tb_branch_sequencer;
   import seq_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        bus = '0;
   logic [3:0]        fin = '0;
   logic              stall = 1'b0;
   logic              step_last = 1'b0;
   logic [STEP_W-1:0] step;
   logic [7:0]        ir;
   logic              ir_load;
   logic              taken;
   logic              abort;
   logic              overrun;

   logic [3:0] ce_cond = '0;
   logic [3:0] ce_fin = '0;
   logic       ce_res;

   int checks = 0;
   int errors = 0;
   bit stim_done = 1'b0;

   typedef struct {
      logic [2:0] st;
      logic [7:0] ir;
      logic       ld;
      logic       tk;
      logic       ab;
      logic       ov;
      string      tag;
   } exp_t;

   exp_t sb[$];

   branch_sequencer #(.BRANCH_OP(4'hE), .MAX_STEP(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .fin       (fin),
      .stall     (stall),
      .step_last (step_last),
      .step      (step),
      .ir        (ir),
      .ir_load   (ir_load),
      .taken     (taken),
      .abort     (abort),
      .overrun   (overrun)
   );

   cond_eval u_ce (
      .cond   (ce_cond),
      .fin    (ce_fin),
      .result (ce_res)
   );

   always #5 clk = ~clk;

   // Reference condition model: even/odd codes are a base test and its inverse.
   function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
      logic nn, zz, cc_, vv, base;
      nn = f[0]; zz = f[1]; cc_ = f[2]; vv = f[3];
      case (cc[3:1])
         3'd0: base = zz;
         3'd1: base = cc_;
         3'd2: base = nn;
         3'd3: base = vv;
         3'd4: base = cc_ & ~zz;
         3'd5: base = ~(nn ^ vv);
         3'd6: base = ~zz & ~(nn ^ vv);
         default: base = 1'b1;
      endcase
      return base ^ cc[0];
   endfunction

   // One clock: drive inputs at the falling edge, queue the state expected after the next rising edge.
   task automatic cyc(input logic rst, input logic stl, input logic [7:0] b,
                      input logic [3:0] f, input logic sl,
                      input logic [2:0] es, input logic [7:0] eir,
                      input logic et, input logic ea, input logic eo, input string tag);
      exp_t e;
      @(negedge clk);
      reset = rst; stall = stl; bus = b; fin = f; step_last = sl;
      e.st = es; e.ir = eir; e.ld = (es == 3'd1) && !stl;
      e.tk = et; e.ab = ea; e.ov = eo; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic chk(input string name, input string tag, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, req);
      end
   endtask

   // Monitor: after every rising edge, pop the queued expectation and compare all outputs.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("step",    e.tag, int'(step),    int'(e.st));
         chk("ir",      e.tag, int'(ir),      int'(e.ir));
         chk("ir_load", e.tag, int'(ir_load), int'(e.ld));
         chk("taken",   e.tag, int'(taken),   int'(e.tk));
         chk("abort",   e.tag, int'(abort),   int'(e.ab));
         chk("overrun", e.tag, int'(overrun), int'(e.ov));
      end
   end

   initial begin
      // Exhaustive standalone condition evaluator sweep.
      for (int i = 0; i < 256; i++) begin
         ce_cond = 4'(i >> 4);
         ce_fin  = 4'(i);
         #1;
         chk("cond_eval", $sformatf("cc%0h_f%0h", ce_cond, ce_fin), int'(ce_res),
             int'(ref_cond(ce_cond, ce_fin)));
      end

      cyc(1,0,8'h00,4'h0,0, 3'd0,8'h00,0,0,0, "rst");
      // Build up to step 4 of a non-branch, then reset while stalled.
      cyc(0,0,8'h30,4'h0,0, 3'd1,8'h00,0,0,0, "pre_a");
      cyc(0,0,8'h30,4'h0,0, 3'd2,8'h30,0,0,0, "pre_b");
      cyc(0,0,8'h30,4'h0,0, 3'd3,8'h30,1,0,0, "pre_ev");
      cyc(0,0,8'h30,4'h0,0, 3'd4,8'h30,1,0,0, "pre_x");
      cyc(1,1,8'h30,4'h0,0, 3'd0,8'h00,0,0,0, "rst_mid");
      // BEQ taken with Z=1; flags change in EXEC must not matter.
      cyc(0,0,8'h00,4'h2,1, 3'd1,8'h00,0,0,0, "beq_fa");
      cyc(0,0,8'hE0,4'h2,1, 3'd2,8'hE0,0,0,0, "beq_fb");
      cyc(0,0,8'h00,4'h2,0, 3'd3,8'hE0,1,0,0, "beq_ev");
      cyc(0,0,8'h00,4'h0,0, 3'd4,8'hE0,1,0,0, "beq_x4");
      cyc(0,0,8'h00,4'h0,1, 3'd0,8'hE0,1,0,0, "beq_end");
      // BEQ untaken with Z=0.
      cyc(0,0,8'h00,4'h0,0, 3'd1,8'hE0,1,0,0, "bne_fa");
      cyc(0,0,8'hE0,4'h0,0, 3'd2,8'hE0,1,0,0, "bne_fb");
      cyc(0,0,8'h00,4'h0,0, 3'd0,8'hE0,0,1,0, "bne_ab");
      cyc(0,0,8'h00,4'h0,0, 3'd1,8'hE0,0,0,0, "bne_after");
      // GE taken with N=V=1, then untaken with V=1,N=0.
      cyc(0,0,8'hEA,4'h9,0, 3'd2,8'hEA,0,0,0, "ge1_fb");
      cyc(0,0,8'h00,4'h9,0, 3'd3,8'hEA,1,0,0, "ge1_ev");
      cyc(0,0,8'h00,4'h9,1, 3'd0,8'hEA,1,0,0, "ge1_end");
      cyc(0,0,8'h00,4'h8,0, 3'd1,8'hEA,1,0,0, "ge2_fa");
      cyc(0,0,8'hEA,4'h8,0, 3'd2,8'hEA,1,0,0, "ge2_fb");
      cyc(0,0,8'h00,4'h8,0, 3'd0,8'hEA,0,1,0, "ge2_ab");
      // Non-branch without step_last overruns at step 7.
      cyc(0,0,8'h00,4'h0,0, 3'd1,8'hEA,0,0,0, "ov_fa");
      cyc(0,0,8'h30,4'h0,0, 3'd2,8'h30,0,0,0, "ov_fb");
      cyc(0,0,8'h00,4'h0,0, 3'd3,8'h30,1,0,0, "ov_ev");
      cyc(0,0,8'h00,4'h0,0, 3'd4,8'h30,1,0,0, "ov_4");
      cyc(0,0,8'h00,4'h0,0, 3'd5,8'h30,1,0,0, "ov_5");
      cyc(0,0,8'h00,4'h0,0, 3'd6,8'h30,1,0,0, "ov_6");
      cyc(0,0,8'h00,4'h0,0, 3'd7,8'h30,1,0,0, "ov_7");
      cyc(0,0,8'h00,4'h0,0, 3'd0,8'h30,1,0,1, "ov_pulse");
      cyc(0,0,8'h00,4'h0,0, 3'd1,8'h30,1,0,0, "ov_after");
      // Stall in FETCH_B with a changing bus; release with BNE and Z=0.
      cyc(0,1,8'hE5,4'h0,0, 3'd1,8'h30,1,0,0, "stl_1");
      cyc(0,1,8'h77,4'h0,0, 3'd1,8'h30,1,0,0, "stl_2");
      cyc(0,1,8'hE0,4'h0,0, 3'd1,8'h30,1,0,0, "stl_3");
      cyc(0,0,8'hE1,4'h0,0, 3'd2,8'hE1,1,0,0, "stl_rel");
      cyc(0,0,8'h00,4'h0,0, 3'd3,8'hE1,1,0,0, "stl_ev");
      cyc(0,0,8'h00,4'h0,1, 3'd0,8'hE1,1,0,0, "stl_end");
      // Non-branch finishing in EVAL goes straight back to fetch.
      cyc(0,0,8'h00,4'h0,0, 3'd1,8'hE1,1,0,0, "nb_fa");
      cyc(0,0,8'h12,4'h0,0, 3'd2,8'h12,1,0,0, "nb_fb");
      cyc(0,0,8'h00,4'h0,1, 3'd0,8'h12,1,0,0, "nb_ev");
      stim_done = 1'b1;
   end

   initial begin
      int guard;
      guard = 0;
      while (!stim_done && guard < 2000) begin
         @(posedge clk);
         guard++;
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (!stim_done || sb.size() != 0) begin
         errors++;
         $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0", stim_done, sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Microstep sequencer that consumes the 4-bit flag word (`fout`) produced by the flags register and decides whether a conditional instruction runs to completion. It owns the fetch/decode microstep counter, latches the instruction byte from the bus, evaluates the condition field against the flags in a dedicated evaluate step, and aborts untaken branches back to fetch. It sits between the flags register and the microcode ROM address generator.

## Interface
- `BRANCH_OP`, 4'hE: opcode class (`ir[7:4]`) treated as a conditional branch.
- `MAX_STEP`, 7: last legal microstep; reaching it without `step_last` forces an overrun return to fetch.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next `clk` edge.
- `bus`  in  8  instruction byte; sampled only at the end of step 1.
- `fin`  in  4  flags `{V,C,Z,N}` (bit3..bit0); must be stable during step 2.
- `stall`  in  1  memory wait; freezes every register while high.
- `step_last`  in  1  microcode ROM end-of-instruction mark for the current step.
- `step`  out  3  current microstep, 0..MAX_STEP.
- `ir`  out  8  latched instruction.
- `ir_load`  out  1  combinational, `step==1 && !stall`.
- `taken`  out  1  registered condition result of the last evaluated instruction.
- `abort`  out  1  one-cycle pulse: branch not taken.
- `overrun`  out  1  one-cycle pulse: MAX_STEP reached without `step_last`.

## Operation
- FSM states: FETCH_A (step 0), FETCH_B (step 1), EVAL (step 2), EXEC (step 3..MAX_STEP).
- FETCH_A -> FETCH_B; FETCH_B -> EVAL, `ir <= bus`.
- EVAL, branch (`ir[7:4]==BRANCH_OP`): `cond = eval(ir[3:0], fin)`, `taken <= cond`. If cond=0: `abort` pulses, step -> 0, FETCH_A. If cond=1: step -> 3, EXEC.
- EVAL, non-branch: `taken <= 1`; if `step_last` -> FETCH_A, else step -> 3, EXEC.
- EXEC: `step_last` -> step 0, FETCH_A; else step+1. At step==MAX_STEP with `!step_last`: `overrun` pulses, step -> 0, FETCH_A (no wrap to 8).
- Condition codes: 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !C|Z, A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE Z|(N!=V), E AL 1, F NV 0.
- `stall` high: state, step, ir, taken unchanged; `abort`/`overrun` forced 0 (pulses occur only on an advancing edge; a stalled EVAL re-evaluates with the then-current `fin`).

## Timing
- Reset values: step=0, state=FETCH_A, ir=8'h00, taken=0, abort=0, overrun=0.
- `reset` overrides `stall` and any in-flight instruction; the next cycle is FETCH_A.
- Unstalled latency: fetch 2 cycles; untaken branch returns to step 0 three edges after entering step 0 (steps 0,1,2,0).
- `abort`, `overrun`, `taken` are registered: visible in the cycle after the deciding edge, together with step=0 (abort/overrun) or step=3.
- `step_last` is ignored in FETCH_A/FETCH_B.
- `fin` is read only in EVAL; flag changes in EXEC do not affect `taken`.

## Structure
- Shared package `seq_pkg`: state enum, condition-code enum (16 values), flag bit indices (N=0, Z=1, C=2, V=3), step width constant.
- Sub-module `cond_eval`: purely combinational `(cond[3:0], fin[3:0]) -> result`; instantiated once; verified exhaustively standalone.

## Test plan
- Reset mid-EXEC (step 4, stall=1) -> next cycle step=0, ir=00, taken=0, abort=0.
- bus=E0 (BEQ), fin=4'b0010 -> step 0,1,2,3, taken=1, abort=0; `step_last` at step 4 -> step 0.
- bus=E0, fin=4'b0000 -> step 0,1,2,0; abort high exactly one cycle; taken=0.
- bus=EA (GE), fin=4'b1001 (V=1,N=1) -> taken=1; fin=4'b1000 -> abort.
- bus=30, `step_last` never asserted -> steps 0..7, overrun pulse, step=0.
- stall held 3 cycles in FETCH_B with bus changing, released with bus=E1, fin Z=0 -> ir=E1, taken=1, no pulse during stall.
